// File: rtl/pll_rst_seq_pkg.sv
// ============================================================================
// pll_rst_seq_pkg: shared state encoding and counter sizing for pll_reset_seq.
// Rev 1.0
// ============================================================================
`default_nettype none

package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    POWERDOWN = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int STATS_W      = 8;
  localparam int RETRY_PORT_W = 2;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_qual.sv
// ============================================================================
// pll_lock_qual: synchronises raw PLL lock and requires LOCK_FILTER steady
// synced-high cycles before asserting lock_ok. Rev 1.0
// ============================================================================
`default_nettype none

module pll_lock_qual
  import pll_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pll_lock,
  output logic lock_ok
);

  localparam int FILT_W = cnt_w(LOCK_FILTER);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      filt_cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      filt_cnt <= '0;
      lock_ok  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      // A single low sample restarts qualification; the count saturates once met.
      if (!synced) begin
        filt_cnt <= '0;
        lock_ok  <= 1'b0;
      end else if (filt_cnt != FILT_W'(LOCK_FILTER)) begin
        filt_cnt <= filt_cnt + 1'b1;
        lock_ok  <= (filt_cnt == FILT_W'(LOCK_FILTER - 1));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pll_reset_seq.sv
// ============================================================================
// pll_reset_seq: PLL supervisor with lock-timeout retry and staggered release
// of NUM_CH resets. Define PLL_RST_SEQ_STATS_EN for lock_loss_cnt/retry_cnt.
// Rev 1.0
// ============================================================================
`default_nettype none

module pll_reset_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_FILTER  = 8,
  parameter int PD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pll_lock,
  input  logic              restart,
  output logic              pll_powerdown_n,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              ready,
  output logic              fault
`ifdef PLL_RST_SEQ_STATS_EN
  , output logic [STATS_W-1:0]      lock_loss_cnt
  , output logic [RETRY_PORT_W-1:0] retry_cnt
`endif
);

  localparam int PD_W  = cnt_w(PD_CYCLES);
  localparam int TO_W  = cnt_w(LOCK_TIMEOUT);
  localparam int STG_W = cnt_w(STAGGER);
  localparam int RTY_W = cnt_w(MAX_RETRIES);

  state_t             state;
  logic [PD_W-1:0]    pd_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [STG_W-1:0]   stg_cnt;
  logic [RTY_W-1:0]   retries;
  logic               lock_ok;
  logic               loss_event;

  pll_lock_qual #(
    .SYNC_STAGES (SYNC_STAGES),
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_qual (
    .clock    (clock),
    .reset_n  (reset_n),
    .pll_lock (pll_lock),
    .lock_ok  (lock_ok)
  );

  // lock_ok is held high throughout RELEASE/RUN, so seeing it low there means it fell.
  assign loss_event = ((state == RELEASE) || (state == RUN)) && !lock_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= POWERDOWN;
      pd_cnt          <= '0;
      to_cnt          <= '0;
      stg_cnt         <= '0;
      retries         <= '0;
      pll_powerdown_n <= 1'b0;
      rst_out_n       <= '0;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else if (restart || loss_event) begin
      state           <= POWERDOWN;
      pd_cnt          <= '0;
      to_cnt          <= '0;
      stg_cnt         <= '0;
      pll_powerdown_n <= 1'b0;
      rst_out_n       <= '0;
      ready           <= 1'b0;
      if (restart) begin
        retries <= '0;
        fault   <= 1'b0;
      end
    end else begin
      case (state)
        POWERDOWN: begin
          if (pd_cnt == PD_W'(PD_CYCLES - 1)) begin
            state           <= WAIT_LOCK;
            pd_cnt          <= '0;
            to_cnt          <= '0;
            pll_powerdown_n <= 1'b1;
          end else begin
            pd_cnt <= pd_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_ok) begin
            state     <= RELEASE;
            stg_cnt   <= '0;
            rst_out_n <= NUM_CH'(1);
          end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
            retries         <= retries + 1'b1;
            to_cnt          <= '0;
            pd_cnt          <= '0;
            pll_powerdown_n <= 1'b0;
            if (retries == RTY_W'(MAX_RETRIES - 1)) begin
              state <= FAIL;
              fault <= 1'b1;
            end else begin
              state <= POWERDOWN;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RELEASE: begin
          // Released bits are always contiguous from bit 0, so shift in the next one.
          if (rst_out_n[NUM_CH-1]) begin
            state   <= RUN;
            ready   <= 1'b1;
            retries <= '0;
          end else if (stg_cnt == STG_W'(STAGGER - 1)) begin
            stg_cnt   <= '0;
            rst_out_n <= NUM_CH'({rst_out_n, 1'b1});
          end else begin
            stg_cnt <= stg_cnt + 1'b1;
          end
        end
        RUN, FAIL: begin
        end
        default: begin
          state <= POWERDOWN;
        end
      endcase
    end
  end

`ifdef PLL_RST_SEQ_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_cnt <= '0;
    end else if (loss_event && (lock_loss_cnt != '1)) begin
      lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

  assign retry_cnt = RETRY_PORT_W'(retries);
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
// ============================================================================
// tb_pll_reset_seq: timestamp-based reference model with per-cycle compare,
// directed scenarios and random lock/restart traffic. Honours PLL_RST_SEQ_STATS_EN.
// ============================================================================
`default_nettype none

module tb_pll_reset_seq;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int FILT = 8;
  localparam int PD   = 16;
  localparam int TO   = 64;
  localparam int STG  = 8;
  localparam int MR   = 3;

  localparam int M_PD   = 0;
  localparam int M_WL   = 1;
  localparam int M_REL  = 2;
  localparam int M_RUN  = 3;
  localparam int M_FAIL = 4;

  logic           clock;
  logic           reset_n;
  logic           pll_lock;
  logic           restart;
  logic           pll_powerdown_n;
  logic [NCH-1:0] rst_out_n;
  logic           ready;
  logic           fault;
`ifdef PLL_RST_SEQ_STATS_EN
  logic [7:0]     lock_loss_cnt;
  logic [1:0]     retry_cnt;
`endif

  pll_reset_seq #(
    .NUM_CH       (NCH),
    .SYNC_STAGES  (SYNC),
    .LOCK_FILTER  (FILT),
    .PD_CYCLES    (PD),
    .LOCK_TIMEOUT (TO),
    .STAGGER      (STG),
    .MAX_RETRIES  (MR)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pll_lock        (pll_lock),
    .restart         (restart),
    .pll_powerdown_n (pll_powerdown_n),
    .rst_out_n       (rst_out_n),
    .ready           (ready),
    .fault           (fault)
`ifdef PLL_RST_SEQ_STATS_EN
    , .lock_loss_cnt (lock_loss_cnt)
    , .retry_cnt     (retry_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  // Model: phase plus the edge number at which it was entered.
  int cyc;
  int m_st;
  int m_t;
  int m_retries;
  int m_loss;
  bit m_lock_ok;
  int run_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    cyc       = 0;
    m_st      = M_PD;
    m_t       = 0;
    m_retries = 0;
    m_loss    = 0;
    m_lock_ok = 1'b0;
    run_hist.delete();
    repeat (SYNC) run_hist.push_back(0);
  endtask

  function automatic logic exp_pd_n();
    return (m_st == M_WL) || (m_st == M_REL) || (m_st == M_RUN);
  endfunction

  function automatic logic [NCH-1:0] exp_rst();
    int k;
    logic [NCH:0] ones;
    if (m_st == M_RUN) return '1;
    if (m_st != M_REL) return '0;
    k = (cyc - m_t) / STG + 1;
    if (k > NCH) k = NCH;
    ones = (NCH + 1)'((1 << k) - 1);
    return ones[NCH-1:0];
  endfunction

  always @(posedge clock) begin : model_step
    bit lo;
    bit loss;
    int r;
    if (reset_n) begin
      cyc++;
      lo   = m_lock_ok;
      loss = ((m_st == M_REL) || (m_st == M_RUN)) && !lo;
      if (loss && m_loss < 255) m_loss++;
      if (restart) begin
        m_st = M_PD; m_t = cyc; m_retries = 0;
      end else if (loss) begin
        m_st = M_PD; m_t = cyc;
      end else begin
        case (m_st)
          M_PD: if (cyc - m_t == PD) begin m_st = M_WL; m_t = cyc; end
          M_WL: begin
            if (lo) begin
              m_st = M_REL; m_t = cyc;
            end else if (cyc - m_t == TO) begin
              m_retries++;
              m_st = (m_retries == MR) ? M_FAIL : M_PD;
              m_t  = cyc;
            end
          end
          M_REL: if (cyc - m_t == (NCH - 1) * STG + 1) begin m_st = M_RUN; m_retries = 0; end
          default: ;
        endcase
      end
      // lock_ok after this edge: the run of high raw samples SYNC edges back reached FILT.
      r = pll_lock ? run_hist[run_hist.size() - 1] + 1 : 0;
      run_hist.push_back(r);
      m_lock_ok = (run_hist[run_hist.size() - 1 - SYNC] >= FILT);
      void'(run_hist.pop_front());
    end
  end

  always @(negedge clock) begin
    if (reset_n && cmp_en) begin
      chk("pd_n", 32'(pll_powerdown_n), 32'(exp_pd_n()));
      chk("rst_out_n", 32'(rst_out_n), 32'(exp_rst()));
      chk("ready", 32'(ready), 32'(m_st == M_RUN));
      chk("fault", 32'(fault), 32'(m_st == M_FAIL));
`ifdef PLL_RST_SEQ_STATS_EN
      chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
      chk("retry_cnt", 32'(retry_cnt), 32'(m_retries));
`endif
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic assert_reset();
    #3 reset_n = 1'b0;
    #1 model_reset();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_pd_n", 32'(pll_powerdown_n), 32'd0);
    chk("reset_rst", 32'(rst_out_n), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Lock arrives at cycle 30, staggered release follows.
    wait_cyc(15); chk("t1_pd_n_c15", 32'(pll_powerdown_n), 32'd0);
    wait_cyc(16); chk("t1_pd_n_c16", 32'(pll_powerdown_n), 32'd1);
    wait_cyc(30); pll_lock = 1'b1;
    wait_cyc(40); chk("t1_rst_c40", 32'(rst_out_n), 32'h0);
    wait_cyc(41); chk("t1_rst_c41", 32'(rst_out_n), 32'h1);
    wait_cyc(49); chk("t1_rst_c49", 32'(rst_out_n), 32'h3);
    wait_cyc(57); chk("t1_rst_c57", 32'(rst_out_n), 32'h7);
    wait_cyc(65); chk("t1_rst_c65", 32'(rst_out_n), 32'hF);
                  chk("t1_ready_c65", 32'(ready), 32'd0);
    wait_cyc(66); chk("t1_ready_c66", 32'(ready), 32'd1);

    // One-cycle lock dropout in RUN.
    wait_cyc(80); pll_lock = 1'b0;
    @(negedge clock); pll_lock = 1'b1;
    wait_cyc(83); chk("t3_ready_c83", 32'(ready), 32'd1);
    wait_cyc(84); chk("t3_rst_c84", 32'(rst_out_n), 32'h0);
                  chk("t3_ready_c84", 32'(ready), 32'd0);
`ifdef PLL_RST_SEQ_STATS_EN
                  chk("t3_loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif
    wait_cyc(125); chk("t3_ready_c125", 32'(ready), 32'd0);
    wait_cyc(126); chk("t3_ready_c126", 32'(ready), 32'd1);

    // Restart coinciding with a lock loss in RUN.
    wait_cyc(140); pll_lock = 1'b0;
    @(negedge clock); pll_lock = 1'b1;
    wait_cyc(143); restart = 1'b1;
    @(negedge clock); restart = 1'b0;
    chk("t6_rst_c144", 32'(rst_out_n), 32'h0);
`ifdef PLL_RST_SEQ_STATS_EN
    chk("t6_loss_cnt", 32'(lock_loss_cnt), 32'd2);
    chk("t6_retry_cnt", 32'(retry_cnt), 32'd0);
`endif
    wait_cyc(160); chk("t6_pd_n_c160", 32'(pll_powerdown_n), 32'd1);
    wait_cyc(186); chk("t6_ready_c186", 32'(ready), 32'd1);

    // Asynchronous reset in the middle of RELEASE.
    wait_cyc(200); restart = 1'b1;
    @(negedge clock); restart = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (rst_out_n == 4'b0011) seen = 1'b1;
    end
    chk("t5_reached_0011", 32'(seen), 32'd1);
    assert_reset();
    chk("t5_async_pd_n", 32'(pll_powerdown_n), 32'd0);
    chk("t5_async_rst", 32'(rst_out_n), 32'd0);
    chk("t5_async_ready", 32'(ready), 32'd0);
    chk("t5_async_fault", 32'(fault), 32'd0);
    release_reset();
    wait_cyc(16); chk("t5_pd_n_c16", 32'(pll_powerdown_n), 32'd1);
    wait_cyc(17); chk("t5_rst_c17", 32'(rst_out_n), 32'h1);
    wait_cyc(42); chk("t5_ready_c42", 32'(ready), 32'd1);

    // Lock never comes: three timeouts, then FAIL.
    wait_cyc(45); pll_lock = 1'b0;
    assert_reset();
    release_reset();
    wait_cyc(79);  chk("t2_pd_n_c79", 32'(pll_powerdown_n), 32'd1);
    wait_cyc(80);  chk("t2_pd_n_c80", 32'(pll_powerdown_n), 32'd0);
    wait_cyc(96);  chk("t2_pd_n_c96", 32'(pll_powerdown_n), 32'd1);
    wait_cyc(239); chk("t2_fault_c239", 32'(fault), 32'd0);
`ifdef PLL_RST_SEQ_STATS_EN
                   chk("t2_retry_c239", 32'(retry_cnt), 32'd2);
`endif
    wait_cyc(240); chk("t2_fault_c240", 32'(fault), 32'd1);
                   chk("t2_pd_n_c240", 32'(pll_powerdown_n), 32'd0);
                   chk("t2_rst_c240", 32'(rst_out_n), 32'h0);
    wait_cyc(250); restart = 1'b1;
    wait_cyc(251); restart = 1'b0;
                   chk("t2_fault_c251", 32'(fault), 32'd0);

    // Chattering lock (5 high, 1 low) never qualifies; timeout retry instead.
    while (cyc < 346) begin
      pll_lock = ((cyc % 6) < 5);
      if (cyc == 330) chk("t4_pd_n_c330", 32'(pll_powerdown_n), 32'd1);
      if (cyc == 331) begin
        chk("t4_pd_n_c331", 32'(pll_powerdown_n), 32'd0);
        chk("t4_rst_c331", 32'(rst_out_n), 32'h0);
`ifdef PLL_RST_SEQ_STATS_EN
        chk("t4_retry_c331", 32'(retry_cnt), 32'd1);
`endif
      end
      @(negedge clock);
    end

    // Random lock activity and occasional restarts.
    for (int i = 0; i < 4000; i++) begin
      if (pll_lock) begin
        if ($urandom_range(0, 119) == 0) pll_lock = 1'b0;
      end else begin
        if ($urandom_range(0, 29) == 0) pll_lock = 1'b1;
      end
      restart = ($urandom_range(0, 299) == 0);
      @(negedge clock);
    end
    restart = 1'b0;
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
